// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract block.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } flags_t;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 2;

  // Two's-complement overflow: operands agree in sign and the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One SW-bit ripple slice of the segmented carry chain.
module addsub_slice #(
  parameter int unsigned SW = 16
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout
);

  // Full add of the slice including carry-in; carry-out is the extra top bit.
  always_comb begin
    {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with the carry chain cut into STAGES
// slices. Stage k adds bits [k*SW +: SW]; operand bits not yet consumed travel
// with the partial sum. All stages advance together whenever the output
// register is empty or being consumed.
// Optional feature: define ADDSUB_FLAGS_EN to add the registered {ovf,neg,zero}
// flags output.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic             w_adv;
  logic             w_cin0;
  logic [WIDTH-1:0] w_b_eff;

  assign w_adv    = out_ready || !out_valid;
  assign in_ready = w_adv;
  assign w_cin0   = (op_e'(sub) == OP_SUB);
  assign w_b_eff  = w_cin0 ? ~b : b;

  // Each stage keeps only the operand bits still to be added, so the operand
  // registers shrink by SW per stage and the last stage carries none.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO   = k * SW;
    localparam int unsigned DONE = LO + SW;

    logic [WIDTH-LO-1:0] w_a_src;
    logic [WIDTH-LO-1:0] w_b_src;
    logic                w_cin;
    logic                w_vin;
    logic [SW-1:0]       w_slice_sum;
    logic                w_slice_cout;
    logic [DONE-1:0]     w_sum_next;
    logic                r_v;
    logic                r_c;
    logic [DONE-1:0]     r_sum;

    if (k == 0) begin : g_head
      assign w_a_src    = a;
      assign w_b_src    = w_b_eff;
      assign w_cin      = w_cin0;
      assign w_vin      = in_valid;
      assign w_sum_next = w_slice_sum;
    end else begin : g_body
      assign w_a_src    = g_stage[k-1].g_ops.r_a;
      assign w_b_src    = g_stage[k-1].g_ops.r_b;
      assign w_cin      = g_stage[k-1].r_c;
      assign w_vin      = g_stage[k-1].r_v;
      assign w_sum_next = {w_slice_sum, g_stage[k-1].r_sum};
    end

    addsub_slice #(.SW(SW)) u_slice (
      .i_a    (w_a_src[SW-1:0]),
      .i_b    (w_b_src[SW-1:0]),
      .i_cin  (w_cin),
      .o_sum  (w_slice_sum),
      .o_cout (w_slice_cout)
    );

    // Stage valid, carry and partial sum; flush drops validity but keeps data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (flush) begin
        r_v   <= 1'b0;
      end else if (w_adv) begin
        r_v   <= w_vin;
        r_c   <= w_slice_cout;
        r_sum <= w_sum_next;
      end
    end

    if (k < LAST) begin : g_ops
      logic [WIDTH-DONE-1:0] r_a;
      logic [WIDTH-DONE-1:0] r_b;

      // Forward the operand bits that later stages still need.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && !flush) begin
          r_a <= w_a_src[WIDTH-LO-1:SW];
          r_b <= w_b_src[WIDTH-LO-1:SW];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].r_v;
  assign sum       = g_stage[LAST].r_sum;
  assign cout      = g_stage[LAST].r_c;

`ifdef ADDSUB_FLAGS_EN
  flags_t w_flags_next;
  flags_t r_flags;

  // Flags derive from the final slice's operand MSBs and the completed sum.
  always_comb begin
    w_flags_next      = '0;
    w_flags_next.zero = (g_stage[LAST].w_sum_next == '0);
    w_flags_next.neg  = g_stage[LAST].w_sum_next[WIDTH-1];
    w_flags_next.ovf  = signed_ovf(g_stage[LAST].w_a_src[SW-1],
                                   g_stage[LAST].w_b_src[SW-1],
                                   g_stage[LAST].w_sum_next[WIDTH-1]);
  end

  // Flags register alongside the final stage so they stay aligned with sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_adv && !flush) begin
      r_flags <= w_flags_next;
    end
  end

  assign flags = r_flags;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: a 32-bit/2-stage instance checked
// through a scoreboard plus directed checks, and a 64-bit/4-stage instance.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, sub, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
  logic        wd_flush, wd_in_valid, wd_in_ready, wd_sub, wd_out_valid, wd_out_ready, wd_cout;
  logic [63:0] wd_a, wd_b, wd_sum;
`ifdef ADDSUB_FLAGS_EN
  logic [2:0]  flags, wd_flags;
`endif

  pipelined_addsub #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADDSUB_FLAGS_EN
    , .flags(flags)
`endif
  );

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) u_wide (
    .clk(clk), .rst(rst), .flush(wd_flush), .in_valid(wd_in_valid), .in_ready(wd_in_ready),
    .a(wd_a), .b(wd_b), .sub(wd_sub), .out_valid(wd_out_valid), .out_ready(wd_out_ready),
    .sum(wd_sum), .cout(wd_cout)
`ifdef ADDSUB_FLAGS_EN
    , .flags(wd_flags)
`endif
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic [2:0]  fl;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  n_pop = 0;

  function automatic sb_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    sb_t         m;
    logic [31:0] ye;
    logic [32:0] r;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {32'd0, s};
    m.sum = r[31:0];
    m.cout = r[32];
    m.fl[FLAG_ZERO] = (r[31:0] == 32'd0);
    m.fl[FLAG_NEG]  = r[31];
    m.fl[FLAG_OVF]  = (x[31] == ye[31]) && (r[31] != x[31]);
    return m;
  endfunction

  // Scoreboard: pop on output handshake, drop on flush/reset, push on acceptance.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got sum=%h cout=%b, required no output", sum, cout);
        end else begin
          e = sb.pop_front();
          if (sum !== e.sum || cout !== e.cout) begin
            n_fail++;
            $display("FAIL sb_result: got sum=%h cout=%b, required sum=%h cout=%b", sum, cout, e.sum, e.cout);
          end
`ifdef ADDSUB_FLAGS_EN
          else if (flags !== e.fl) begin
            n_fail++;
            $display("FAIL sb_flags: got %b, required %b", flags, e.fl);
          end
`endif
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(a, b, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    wd_flush = 1'b0; wd_in_valid = 1'b0; wd_a = '0; wd_b = '0; wd_sub = 1'b0; wd_out_ready = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (sum !== 32'd0 || cout !== 1'b0) begin n_fail++; $display("FAIL reset_sum: got %h/%b, required 0/0", sum, cout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, required 000", flags); end
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_sub();
    typedef struct packed {
      logic [31:0] x, y; logic s; logic [31:0] es; logic ec; logic [2:0] ef;
    } vec_t;
    vec_t v[7];
    v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 3'b001};
    v[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 3'b010};
    v[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 3'b000};
    v[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 3'b110};
    v[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 3'b100};
    v[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 3'b001};
    v[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; a = v[i].x; b = v[i].y; sub = v[i].s;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addsub_early[%0d]: out_valid got %b, required 0", i, out_valid); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || sum !== v[i].es || cout !== v[i].ec) begin
        n_fail++;
        $display("FAIL addsub[%0d]: got v=%b sum=%h cout=%b, required v=1 sum=%h cout=%b", i, out_valid, sum, cout, v[i].es, v[i].ec);
      end
`ifdef ADDSUB_FLAGS_EN
      n_cmp++;
      if (flags !== v[i].ef) begin n_fail++; $display("FAIL addsub_flags[%0d]: got %b, required %b", i, flags, v[i].ef); end
`endif
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs[8], ys[8];
    logic        ss[8];
    logic [31:0] hs;
    logic        hc, exp_rdy;
    int          acc, pop0;
    for (int i = 0; i < 8; i++) begin
      xs[i] = $urandom; ys[i] = $urandom; ss[i] = 1'($urandom_range(0, 1));
    end
    acc = 0; pop0 = n_pop; hs = '0; hc = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (acc < 8);
      if (acc < 8) begin a = xs[acc]; b = ys[acc]; sub = ss[acc]; end
      #1;
      exp_rdy = !(c >= 3 && c <= 5);
      n_cmp++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready[c%0d]: got %b, required %b", c, in_ready, exp_rdy); end
      if (c == 3) begin hs = sum; hc = cout; end
      if (c == 4 || c == 5) begin
        n_cmp++;
        if (out_valid !== 1'b1 || sum !== hs || cout !== hc) begin
          n_fail++;
          $display("FAIL b2b_hold[c%0d]: got v=%b sum=%h cout=%b, required v=1 sum=%h cout=%b", c, out_valid, sum, cout, hs, hc);
        end
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (acc != 8) begin n_fail++; $display("FAIL b2b_accepted: got %0d, required 8", acc); end
    for (int t = 0; t < 10 && (sb.size() != 0 || out_valid); t++) tick();
    n_cmp++;
    if (n_pop - pop0 != 8) begin n_fail++; $display("FAIL b2b_results: got %0d, required 8", n_pop - pop0); end
  endtask

  task automatic test_flush();
    int pop0;
    pop0 = n_pop;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0;
    tick();
    a = 32'h3333_3333; b = 32'h0000_0001; sub = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: out_valid got %b, required 1", out_valid); end
    a = 32'h5555_5555; b = 32'h0000_0005; sub = 1'b0; flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_stalled: got %b, required 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: out_valid got %b, required 0", out_valid); end
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: out_valid got %b, required 0", t, out_valid); end
    end
    in_valid = 1'b1; a = 32'h0000_00AA; b = 32'h0000_0011; sub = 1'b0; flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready_free: got %b, required 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_priority[%0d]: out_valid got %b, required 0", t, out_valid); end
    end
    n_cmp++;
    if (n_pop != pop0) begin n_fail++; $display("FAIL flush_results: got %0d outputs, required 0", n_pop - pop0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'h0000_FFFF : $urandom;
      sub = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 10 && (sb.size() != 0 || out_valid); t++) tick();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL random_drain: %0d results outstanding, required 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: out_valid got %b, required 1", out_valid); end
    #3;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: got v=%b sum=%h cout=%b, required 0/0/0", out_valid, sum, cout);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b, required 1", in_ready); end
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1; a = 32'd3; b = 32'd4; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_first_early: out_valid got %b, required 0", out_valid); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || sum !== 32'd7 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_first_op: got v=%b sum=%h cout=%b, required 1/00000007/0", out_valid, sum, cout);
    end
    tick();
  endtask

  task automatic test_wide();
    logic [63:0] xa[2], xb[2], es[2];
    logic        xs[2], ec[2];
    logic [2:0]  ef[2];
    xa[0] = '1;    xb[0] = 64'd1; xs[0] = 1'b0; es[0] = 64'd0; ec[0] = 1'b1; ef[0] = 3'b001;
    xa[1] = 64'd0; xb[1] = 64'd1; xs[1] = 1'b1; es[1] = '1;    ec[1] = 1'b0; ef[1] = 3'b010;
    wd_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wd_in_valid = 1'b1; wd_a = xa[i]; wd_b = xb[i]; wd_sub = xs[i];
      #1;
      n_cmp++;
      if (wd_in_ready !== 1'b1) begin n_fail++; $display("FAIL wide_in_ready[%0d]: got %b, required 1", i, wd_in_ready); end
      tick();
      wd_in_valid = 1'b0;
      for (int c = 1; c < 4; c++) begin
        n_cmp++;
        if (wd_out_valid !== 1'b0) begin n_fail++; $display("FAIL wide_early[%0d] cycle %0d: got %b, required 0", i, c, wd_out_valid); end
        tick();
      end
      n_cmp++;
      if (wd_out_valid !== 1'b1 || wd_sum !== es[i] || wd_cout !== ec[i]) begin
        n_fail++;
        $display("FAIL wide[%0d]: got v=%b sum=%h cout=%b, required v=1 sum=%h cout=%b", i, wd_out_valid, wd_sum, wd_cout, es[i], ec[i]);
      end
`ifdef ADDSUB_FLAGS_EN
      n_cmp++;
      if (wd_flags !== ef[i]) begin n_fail++; $display("FAIL wide_flags[%0d]: got %b, required %b", i, wd_flags, ef[i]); end
`endif
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
